// File: rtl/inst_ctrl.sv
// Multi-cycle instruction sequencer: drives fetch strobes, steps each instruction
// through decode/execute/memory/write-back and counts retired instructions.
module inst_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step,
    input  logic        flag,
    input  logic [28:1] IR,
    output logic        Write_IR,
    output logic        Write_PC,
    output logic        PC_s,
    output logic        Write_NZCV,
    output logic        Mem_en,
    output logic        Write_Reg,
    output logic [2:0]  state,
    output logic        busy,
    output logic [15:0] inst_cnt
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        BRANCH = 3'd6
    } state_t;

    // Handshake: no valid/ready pairs here; go is a one-shot request accepted only in IDLE,
    // and a step edge seen while busy is dropped rather than queued.
    state_t      state_q, state_d;
    logic        step_q;
    logic [15:0] cnt_q, cnt_d;
    logic        go, retire;
    logic        is_branch, is_dp, is_ls;
    logic        unused_ir;

    assign go        = run | (step & ~step_q);
    assign is_branch = (IR[28:26] == 3'b101);
    assign is_dp     = (IR[28:27] == 2'b00);
    assign is_ls     = (IR[28:27] == 2'b01);
    assign unused_ir = ^{IR[24:22], IR[20:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            IDLE:    if (go) state_d = FETCH;
            FETCH:   state_d = DECODE;
            DECODE: begin
                if (!flag || !(is_branch || is_dp || is_ls)) retire  = 1'b1;
                else if (is_branch)                          state_d = BRANCH;
                else                                         state_d = EXEC;
            end
            EXEC:    state_d = is_dp ? WB : MEM;
            MEM: begin
                // IR[21] is the load bit for memory instructions
                if (IR[21]) state_d = WB;
                else        retire  = 1'b1;
            end
            WB:      retire = 1'b1;
            BRANCH:  retire = 1'b1;
            default: state_d = IDLE;
        endcase
        if (retire) state_d = run ? FETCH : IDLE;
    end

    assign cnt_d = retire ? cnt_q + 16'd1 : cnt_q;

    always_comb begin
        Write_IR   = 1'b0;
        Write_PC   = 1'b0;
        PC_s       = 1'b0;
        Write_NZCV = 1'b0;
        Mem_en     = 1'b0;
        Write_Reg  = 1'b0;
        case (state_q)
            FETCH: begin
                Write_IR = 1'b1;
                Write_PC = 1'b1;
            end
            EXEC:   Write_NZCV = is_dp & IR[21];
            MEM:    Mem_en     = 1'b1;
            WB:     Write_Reg  = 1'b1;
            BRANCH: begin
                Write_PC  = 1'b1;
                PC_s      = 1'b1;
                Write_Reg = IR[25];
            end
            default: ;
        endcase
    end

    assign state    = state_q;
    assign busy     = (state_q != IDLE);
    assign inst_cnt = cnt_q;
endmodule

// File: doc/inst_ctrl.md
# inst_ctrl

Multi-cycle control sequencer that drives the instruction fetch unit from the other side of its control interface. It issues the Write_IR/Write_PC strobes and consumes the fetched IR and the condition-pass flag. It then steps each instruction through decode, execute, memory and write-back, and emits the datapath enables and a retired-instruction count for the board display. It supports free-run and single-step (push-button) operation.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = free-run, 0 = single-step
- step  in  1  raw button level; a rising edge starts one instruction when idle
- flag  in  1  condition-pass from fetch unit (condition_code vs NZCV); sampled in DECODE only
- IR  in  28  [28:1] instruction bits below the condition field; IR[k] = inst bit k-1
- Write_IR  out  1  load instruction register
- Write_PC  out  1  load program counter
- PC_s  out  1  PC source: 0 = PC+1, 1 = branch target
- Write_NZCV  out  1  update flags
- Mem_en  out  1  data memory access strobe
- Write_Reg  out  1  register file write
- state  out  3  current FSM state code
- busy  out  1  1 whenever state != IDLE
- inst_cnt  out  16  retired-instruction counter

## Operation
- States (encoding): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BRANCH=6; codes 7 and above go to IDLE.
- Start condition `go` = run | step_rise; step_rise = step & ~step_q, with step_q a register (reset 0) updated every cycle.
- IDLE: if go then FETCH, else stay.
- FETCH: Write_IR=1, Write_PC=1, PC_s=0. Always goes to DECODE.
- DECODE classifies IR:
  - branch: IR[28:26]=3'b101
  - data-processing (DP): IR[28:27]=2'b00
  - load/store (LS): IR[28:27]=2'b01
  - all other codes are undefined
- DECODE transitions:
  - flag=0: retire.
  - flag=1 and undefined: retire.
  - flag=1 and branch: BRANCH.
  - flag=1 and DP or LS: EXEC.
- EXEC: Write_NZCV=1 only if class is DP and S bit IR[21]=1.
  - DP: next state WB.
  - LS: next state MEM.
- MEM: Mem_en=1.
  - Load (L bit IR[21]=1): next state WB.
  - Store: retire.
- WB: Write_Reg=1, then retire.
- BRANCH: Write_PC=1, PC_s=1; Write_Reg=1 if link bit IR[25]=1. Then retire.
- Retire means:
  - inst_cnt increments by 1 (16-bit, 0xFFFF wraps to 0x0000).
  - Next state is FETCH if run=1, else IDLE.
- The class and the L/S/link bits are taken from IR directly each cycle. IR holds stable after FETCH, so no internal copy is kept.
- All strobe outputs are a Moore decode of state plus IR bits. Every strobe is 0 in any state not listed for it.

## Timing
- Reset (async, immediate):
  - state=IDLE, step_q=0, inst_cnt=0
  - all strobes 0, PC_s=0, busy=0
- Latency in cycles, counted from FETCH through the retire cycle inclusive:
  - condition-fail or undefined: 2
  - branch: 3
  - DP: 4
  - store: 4
  - load: 5
- Free-run: back-to-back instructions with no IDLE gap; FETCH immediately follows the retire cycle.
- Single-step: the first FETCH occurs the cycle after the clock edge that samples the step rising edge.
  - Holding step high yields exactly one instruction.
  - A step edge while busy is ignored and not queued.
- run falling mid-instruction: the current instruction completes and retires, then the FSM enters IDLE.
- run rising while IDLE: FETCH on the next cycle.
- Asserting rst mid-instruction aborts it: no retire and no count.
- Write_IR and Write_PC are each high for exactly one cycle per FETCH.

## Test plan
- Reset then hold run=0, step=0 for 10 cycles:
  - state=0, busy=0, inst_cnt=0, all strobes 0 throughout.
- run=1, IR=28'h0100000 (DP, S=1), flag=1:
  - state sequence 1,2,3,5 repeating.
  - Write_NZCV high in state 3, Write_Reg high in state 5.
  - inst_cnt +1 every 4 cycles.
- run=1, IR=28'h5100000 (LS, load) then IR=28'h5000000 (store), flag=1:
  - load: states 1,2,3,4,5 (5 cycles), Mem_en in 4, Write_Reg in 5.
  - store: states 1,2,3,4 (4 cycles), no Write_Reg.
- run=1, IR=28'hB000000 (branch with link), flag=1:
  - states 1,2,6; in state 6 Write_PC=1, PC_s=1, Write_Reg=1.
  - Repeat with flag=0: states 1,2 only; inst_cnt still +1.
- run=0, step held high for 20 cycles, with a second step pulse issued while busy:
  - exactly one instruction executes, then IDLE; inst_cnt=1.
- Preload 0xFFFF retirements, retire one more → inst_cnt=0x0000.
- Assert rst during EXEC → outputs reset in the same cycle, with no count change from the aborted instruction.
